logic_unit_sweeper: RTL and testbench



---
 rtl/logic_unit_sweeper_if.sv | 30 +++
 rtl/logic_unit_sweeper.sv | 133 +++++++++++++
 tb/tb_logic_unit_sweeper.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_sweeper_if.sv
// Sweeper bus: start/abort handshake, logic-unit drive/sense, results.
// slave = sweeper side, master = controller/harness side.
interface logic_unit_sweeper_if;
  logic        start;
  logic        abort;
  logic        y_in;
  logic        A;
  logic        B;
  logic        sel_op;
  logic        sel_grp;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [4:0]  mismatches;
  logic        pass;

  modport slave (
    input  start, abort, y_in,
    output A, B, sel_op, sel_grp,
    output busy, done, table_out,
    output mismatches, pass
  );

  modport master (
    output start, abort, y_in,
    input  A, B, sel_op, sel_grp,
    input  busy, done, table_out,
    input  mismatches, pass
  );
endinterface

// File: rtl/logic_unit_sweeper.sv
// Sweeps a 2-input logic unit through all 16 {grp,op,A,B} vectors,
// builds its truth table, and scores it against EXPECTED.
// Ports: clk, rst_n (sync, active low), bus (slave modport):
//   start/abort in, y_in in, A/B/sel_op/sel_grp out,
//   busy/done out, table_out/mismatches/pass results.
module logic_unit_sweeper #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'h781E
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_unit_sweeper_if.slave   bus
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] sh_tbl_q, sh_tbl_d;
  logic [4:0]  sh_cnt_q, sh_cnt_d;
  logic [15:0] tbl_q, tbl_d;
  logic [4:0]  mm_q, mm_d;
  logic        pass_q, pass_d;
  logic [3:0]  drv_q, drv_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    sh_tbl_d = sh_tbl_q;
    sh_cnt_d = sh_cnt_q;
    tbl_d    = tbl_q;
    mm_d     = mm_q;
    pass_d   = pass_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = DRIVE;
          idx_d    = '0;
          cnt_d    = '0;
          sh_tbl_d = '0;
          sh_cnt_d = '0;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          sh_tbl_d[idx_q] = bus.y_in;
          if (bus.y_in != EXPECTED[idx_q])
            sh_cnt_d = sh_cnt_q + 5'd1;
          if (idx_q == 4'd15) begin
            // Publish with the last sample merged so results are
            // already valid while done is high.
            state_d = DONE;
            tbl_d   = sh_tbl_d;
            mm_d    = sh_cnt_d;
            pass_d  = (sh_cnt_d == 5'd0);
          end else begin
            state_d = DRIVE;
            idx_d   = idx_q + 4'd1;
            cnt_d   = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Drive lines track the next state so they line up with busy.
  always_comb begin
    drv_d = '0;
    if (state_d == DRIVE || state_d == SAMPLE)
      drv_d = idx_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      sh_tbl_q <= '0;
      sh_cnt_q <= '0;
      tbl_q    <= '0;
      mm_q     <= '0;
      pass_q   <= 1'b0;
      drv_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      sh_tbl_q <= sh_tbl_d;
      sh_cnt_q <= sh_cnt_d;
      tbl_q    <= tbl_d;
      mm_q     <= mm_d;
      pass_q   <= pass_d;
      drv_q    <= drv_d;
    end
  end

  assign {bus.sel_grp, bus.sel_op, bus.A, bus.B} = drv_q;

  assign bus.busy = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done = (state_q == DONE);

  assign bus.table_out  = tbl_q;
  assign bus.mismatches = mm_q;
  assign bus.pass       = pass_q;

endmodule

// File: tb/tb_logic_unit_sweeper.sv
// Bench for logic_unit_sweeper: SETTLE=1 and SETTLE=3 instances,
// behavioural logic unit with fault modes, scoreboarded results.
module tb_logic_unit_sweeper;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  mm;
    logic        ps;
  } exp_t;

  typedef struct {
    int          mode;
    logic [15:0] tbl;
    logic [4:0]  mm;
    logic        ps;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort, sel;
  int   mode;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];
  vec_t vt[4];

  always #5 clk = ~clk;

  logic_unit_sweeper_if b0();
  logic_unit_sweeper_if b1();

  logic_unit_sweeper #(.SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  logic_unit_sweeper #(.SETTLE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  // mode 0 good, 1 stuck-0, 2 stuck-1, 3 inverted
  function automatic logic yfun(int m, logic [3:0] v);
    logic a, b, op, grp, y;
    {grp, op, a, b} = v;
    if (grp) y = op ? ~(a & b) : (a & b);
    else     y = op ? ~(a | b) : (a | b);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~y;
      default: return y;
    endcase
  endfunction

  assign b0.start = start & ~sel;
  assign b1.start = start & sel;
  assign b0.abort = abort & ~sel;
  assign b1.abort = abort & sel;
  assign b0.y_in  = yfun(mode, {b0.sel_grp, b0.sel_op, b0.A, b0.B});
  assign b1.y_in  = yfun(mode, {b1.sel_grp, b1.sel_op, b1.A, b1.B});

  logic        c_busy, c_done, c_pass;
  logic [3:0]  c_drv;
  logic [15:0] c_tbl;
  logic [4:0]  c_mm;

  assign c_busy = sel ? b1.busy : b0.busy;
  assign c_done = sel ? b1.done : b0.done;
  assign c_pass = sel ? b1.pass : b0.pass;
  assign c_tbl  = sel ? b1.table_out : b0.table_out;
  assign c_mm   = sel ? b1.mismatches : b0.mismatches;
  assign c_drv  = sel ?
    {b1.sel_grp, b1.sel_op, b1.A, b1.B} :
    {b0.sel_grp, b0.sel_op, b0.A, b0.B};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, 32'(c_busy), 0);
    chk({tag, "_done"}, 32'(c_done), 0);
    chk({tag, "_drv"},  32'(c_drv),  0);
    chk({tag, "_tbl"},  32'(c_tbl),  0);
    chk({tag, "_mm"},   32'(c_mm),   0);
    chk({tag, "_pass"}, 32'(c_pass), 0);
  endtask

  // Runs one sweep on the selected DUT, checking vector order,
  // latency, done count and the scoreboarded result.
  task automatic sweep(string tag, logic [15:0] et, logic [4:0] em,
                       logic ep, bit pulses);
    int s, len, lat, bad, dones;
    exp_t e;
    s = sel ? 3 : 1;
    len = 16 * (s + 1);
    lat = -1; bad = 0; dones = 0;
    sb.push_back('{et, em, ep});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 1; n <= len + 20; n++) begin
      if (n <= len) begin
        if (!c_busy || c_drv != 4'((n - 1) / (s + 1))) bad++;
      end
      if (c_done) begin
        dones++;
        if (lat < 0) lat = n;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({tag, "_tbl"},  32'(c_tbl),  32'(e.tbl));
          chk({tag, "_mm"},   32'(c_mm),   32'(e.mm));
          chk({tag, "_pass"}, 32'(c_pass), 32'(e.ps));
        end else begin
          chk({tag, "_sb_empty"}, 1, 0);
        end
      end
      start = (pulses && n < 30 && (n % 7 == 3)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(len + 1));
    chk({tag, "_vec_order"}, 32'(bad), 0);
    chk({tag, "_dones"}, 32'(dones), 1);
  endtask

  task automatic wait_idx(string tag, logic [3:0] want);
    int k;
    k = 0;
    while (c_drv != want && k < 100) begin
      @(negedge clk); k++;
    end
    chk({tag, "_reach_idx"}, 32'(c_drv), 32'(want));
  endtask

  initial begin
    vt[0] = '{1, 16'h0000, 5'd8,  1'b0};
    vt[1] = '{2, 16'hFFFF, 5'd8,  1'b0};
    vt[2] = '{3, 16'h87E1, 5'd16, 1'b0};
    vt[3] = '{0, 16'h781E, 5'd0,  1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    sel = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset0");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      mode = vt[i].mode;
      sweep($sformatf("vec%0d", i), vt[i].tbl, vt[i].mm,
            vt[i].ps, 1'b0);
    end

    // abort mid-sweep keeps previous good results
    mode = 3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idx("abort", 4'd5);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", 32'(c_busy), 0);
    begin
      int d;
      d = 0;
      repeat (40) begin
        if (c_done) d++;
        @(negedge clk);
      end
      chk("abort_no_done", 32'(d), 0);
    end
    chk("abort_tbl",  32'(c_tbl),  32'h781E);
    chk("abort_mm",   32'(c_mm),   0);
    chk("abort_pass", 32'(c_pass), 1);

    // extra start pulses during a sweep are ignored
    mode = 0;
    sweep("pulses", 16'h781E, 5'd0, 1'b1, 1'b1);

    // start with abort in IDLE does nothing
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("st_ab_busy0", 32'(c_busy), 0);
    @(negedge clk);
    chk("st_ab_busy1", 32'(c_busy), 0);

    // SETTLE=3 instance: full sweep, reset mid-sweep, restart
    sel = 1'b1; mode = 0;
    sweep("s3_a", 16'h781E, 5'd0, 1'b1, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idx("s3_rst", 4'd10);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("s3_rst");
    rst_n = 1'b1;
    mode = 2;
    sweep("s3_b", 16'hFFFF, 5'd8, 1'b0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
